// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS main control FSM driving datapath strobes and ALUOp.
// Define MIPS_CTRL_ADDI_EN to build the ADDI_EX/ADDI_WB path; otherwise opcode 6'h08 is illegal.
module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXEC = 4'd6, RCOMP = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
        ADDI_EX = 4'd10, ADDI_WB = 4'd11, IDLE = 4'd15
    } state_t;

    state_t cur, nxt;

    always_ff @(posedge clk or posedge rst)
        if (rst) cur <= IDLE;
        else     cur <= nxt;

    assign state = cur;

    always_comb begin
        nxt         = IDLE;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        illegal_op  = 1'b0;
        case (cur)
            IDLE: nxt = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                nxt     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = EXEC;
                    OP_BEQ:       nxt = BRANCH;
                    OP_J:         nxt = JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      nxt = ADDI_EX;
`else
                    OP_ADDI: begin
                        nxt        = FETCH;
                        illegal_op = 1'b1;
                    end
`endif
                    default: begin
                        nxt        = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                nxt     = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                nxt      = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                nxt      = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                nxt     = RCOMP;
            end
            RCOMP: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                nxt      = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                nxt         = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                nxt      = FETCH;
            end
`ifdef MIPS_CTRL_ADDI_EN
            ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite = 1'b1;
                nxt      = FETCH;
            end
`endif
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed-vector bench for the multicycle MIPS control FSM.
module tb_mips_multicycle_control;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, illegal_op;
    logic [3:0] state;
    logic [16:0] outs;
    int n_checks = 0;
    int n_fail = 0;

    mips_multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCSource(PCSource),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,PCSource,ALUOp,ALUSrcA,ALUSrcB,RegWrite,RegDst,illegal_op}
    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal_op};

    localparam logic [16:0] O_ZERO   = 17'b0_0_0_0_0_0_0_00_00_0_00_0_0_0;
    localparam logic [16:0] O_FETCH  = 17'b1_0_0_1_0_0_1_00_00_0_01_0_0_0;
    localparam logic [16:0] O_FSTALL = 17'b0_0_0_1_0_0_0_00_00_0_01_0_0_0;
    localparam logic [16:0] O_DEC    = 17'b0_0_0_0_0_0_0_00_00_0_11_0_0_0;
    localparam logic [16:0] O_DECILL = 17'b0_0_0_0_0_0_0_00_00_0_11_0_0_1;
    localparam logic [16:0] O_MEMADR = 17'b0_0_0_0_0_0_0_00_00_1_10_0_0_0;
    localparam logic [16:0] O_MEMRD  = 17'b0_0_1_1_0_0_0_00_00_0_00_0_0_0;
    localparam logic [16:0] O_MEMWB  = 17'b0_0_0_0_0_1_0_00_00_0_00_1_0_0;
    localparam logic [16:0] O_MEMWR  = 17'b0_0_1_0_1_0_0_00_00_0_00_0_0_0;
    localparam logic [16:0] O_EXEC   = 17'b0_0_0_0_0_0_0_00_10_1_00_0_0_0;
    localparam logic [16:0] O_RCOMP  = 17'b0_0_0_0_0_0_0_00_00_0_00_1_1_0;
    localparam logic [16:0] O_BRANCH = 17'b0_1_0_0_0_0_0_01_01_1_00_0_0_0;
    localparam logic [16:0] O_JUMP   = 17'b1_0_0_0_0_0_0_10_00_0_00_0_0_0;
    localparam logic [16:0] O_ADDIWB = 17'b0_0_0_0_0_0_0_00_00_0_00_1_0_0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [16:0] ob);
        @(posedge clk);
        #1;
        check({tag, ".state"}, state, st);
        check({tag, ".outs"}, outs, ob);
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'h00;
        #3;
        check("rst.state", state, 4'hF);
        check("rst.outs", outs, O_ZERO);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle.state", state, 4'hF);
        check("idle.outs", outs, O_ZERO);
        step("r.fetch", 4'd0, O_FETCH);
        step("r.dec", 4'd1, O_DEC);
        step("r.exec", 4'd6, O_EXEC);
        step("r.rcomp", 4'd7, O_RCOMP);
        step("r.fetch2", 4'd0, O_FETCH);

        // fetch stall: strobes gated off while memory is busy
        mem_ready = 1'b0;
        #1;
        check("fstall.outs", outs, O_FSTALL);
        step("fstall.hold", 4'd0, O_FSTALL);
        mem_ready = 1'b1;
        opcode = 6'h23;
        #1;
        check("fstall.rel", outs, O_FETCH);
        step("lw.dec", 4'd1, O_DEC);
        step("lw.memadr", 4'd2, O_MEMADR);
        step("lw.memrd1", 4'd3, O_MEMRD);
        mem_ready = 1'b0;
        step("lw.memrd2", 4'd3, O_MEMRD);
        step("lw.memrd3", 4'd3, O_MEMRD);
        step("lw.memrd4", 4'd3, O_MEMRD);
        mem_ready = 1'b1;
        step("lw.memwb", 4'd4, O_MEMWB);
        step("lw.fetch", 4'd0, O_FETCH);

        opcode = 6'h04;
        step("beq.dec", 4'd1, O_DEC);
        step("beq.branch", 4'd8, O_BRANCH);
        step("beq.fetch", 4'd0, O_FETCH);

        opcode = 6'h02;
        step("j.dec", 4'd1, O_DEC);
        step("j.jump", 4'd9, O_JUMP);
        step("j.fetch", 4'd0, O_FETCH);

        opcode = 6'h08;
`ifdef MIPS_CTRL_ADDI_EN
        step("addi.dec", 4'd1, O_DEC);
        step("addi.ex", 4'd10, O_MEMADR);
        step("addi.wb", 4'd11, O_ADDIWB);
        step("addi.fetch", 4'd0, O_FETCH);
`else
        step("addi.dec", 4'd1, O_DECILL);
        step("addi.fetch", 4'd0, O_FETCH);
`endif

        opcode = 6'h3F;
        step("ill.dec", 4'd1, O_DECILL);
        step("ill.fetch", 4'd0, O_FETCH);

        opcode = 6'h2B;
        step("sw.dec", 4'd1, O_DEC);
        step("sw.memadr", 4'd2, O_MEMADR);
        step("sw.memwr", 4'd5, O_MEMWR);
        step("sw.fetch", 4'd0, O_FETCH);

        // SW stalled in MEMWR, then reset mid-cycle
        step("sw2.dec", 4'd1, O_DEC);
        step("sw2.memadr", 4'd2, O_MEMADR);
        step("sw2.memwr", 4'd5, O_MEMWR);
        mem_ready = 1'b0;
        step("sw2.stall", 4'd5, O_MEMWR);
        #2;
        rst = 1'b1;
        #1;
        check("arst.state", state, 4'hF);
        check("arst.memwrite", {31'b0, MemWrite}, 32'd0);
        check("arst.outs", outs, O_ZERO);
        mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step("arst.fetch", 4'd0, O_FETCH);
        step("arst.dec", 4'd1, O_DEC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
